// File: rtl/div_sequencer_pkg.sv
// Shared encodings for the RV32M divide sequencer.
package div_sequencer_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    // alu_op[4:3] tag that marks M-extension operations
    localparam logic [1:0] ALU_TAG_M = 2'b01;

    // alu_op[2:0] encodings of the divide-class operations
    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_datapath.sv
// Restoring shift-subtract divider datapath: operand magnitudes, partial
// remainder/quotient, one-step iteration and final sign correction.
module div_datapath #(
    parameter int XLEN = div_sequencer_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            step,
    input  logic            finish,
    input  logic            spec_load,
    input  logic            is_signed,
    input  logic            rem_sel,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [XLEN-1:0] spec_value,
    output logic [XLEN-1:0] result
);
    import div_sequencer_pkg::*;

    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;
    logic            rsel_q, rsel_d;

    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN:0]   partial;
    logic [XLEN+1:0] diff;
    logic [XLEN-1:0] rem_step, quo_step;

    // One restoring step; the shifted partial remainder keeps its carry-out
    // so divisors at or above 2^(XLEN-1) still compare correctly.
    always_comb begin
        a_abs    = (is_signed && dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
        b_abs    = (is_signed && divisor[XLEN-1])  ? (~divisor + 1'b1)  : divisor;
        partial  = {rem_q, quo_q[XLEN-1]};
        diff     = {1'b0, partial} - {2'b00, dvs_q};
        rem_step = partial[XLEN-1:0];
        quo_step = {quo_q[XLEN-2:0], 1'b0};
        if (!diff[XLEN+1]) begin
            rem_step = diff[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    // Next-state selection for the load/step/finish/special strobes.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        rsel_d  = rsel_q;
        if (load) begin
            rem_d   = '0;
            quo_d   = a_abs;
            dvs_d   = b_abs;
            neg_q_d = is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r_d = is_signed & dividend[XLEN-1];
            rsel_d  = rem_sel;
        end
        if (step) begin
            rem_d = rem_step;
            quo_d = quo_step;
        end
        if (step && finish) begin
            if (rsel_q) res_d = neg_r_q ? (~rem_step + 1'b1) : rem_step;
            else        res_d = neg_q_q ? (~quo_step + 1'b1) : quo_step;
        end
        if (spec_load) begin
            res_d = spec_value;
        end
    end

    // Datapath registers, all cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            rsel_q  <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            rsel_q  <= rsel_d;
        end
    end

    assign result = res_q;

endmodule

// File: rtl/div_sequencer.sv
// EX-stage sequencer for DIV/DIVU/REM/REMU: FSM, step counter, special-case
// detection and pipeline stall; iteration lives in div_datapath.
module div_sequencer #(
    parameter int XLEN  = div_sequencer_pkg::XLEN,
    parameter int CNT_W = div_sequencer_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);
    import div_sequencer_pkg::*;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic            go;
    logic            is_signed;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] spec_value;
    logic            load, step, finish, spec_load;

    // Operand classification: divide-by-zero and signed overflow skip iteration.
    always_comb begin
        go         = start & funct3[2];
        is_signed  = ~funct3[0];
        div_zero   = (divisor == '0);
        ovf        = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
        special    = div_zero | ovf;
        if (funct3[1]) spec_value = div_zero ? dividend : '0;
        else           spec_value = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // Next-state, counter and datapath strobes.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        spec_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go && !flush) begin
                    if (special) begin
                        spec_load = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        load    = 1'b1;
                        count_d = CNT_W'(XLEN - 1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (count_q == '0) begin
                        finish  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and step-counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    div_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .step       (step),
        .finish     (finish),
        .spec_load  (spec_load),
        .is_signed  (is_signed),
        .rem_sel    (funct3[1]),
        .dividend   (dividend),
        .divisor    (divisor),
        .spec_value (spec_value),
        .result     (result)
    );

    assign stall        = go & ~flush & (state_q != S_DONE);
    assign busy         = (state_q == S_CALC);
    assign result_valid = (state_q == S_DONE);

endmodule
